mem_2w4r: RTL and testbench
===========================

Name: mem_2w4r

Overview:
- 16-entry x 32-bit multi-ported storage array: two synchronous write ports, four asynchronous read ports.
- Serves as the storage core of the CPU register file. Reads 0/1 feed operand fetch; reads 2/3 are tied to constant indices to expose fp (r0) and sp (r1).
- Purely a storage block: no handshake and no internal state beyond the array.

Parameters:
- DATA_W, 32, width of each entry and of all data ports.
- ADDR_W, 4, width of every index port.
- DEPTH, 16, number of entries; must equal 2**ADDR_W.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- we0_i  input  1  write enable, port 0.
- we1_i  input  1  write enable, port 1.
- waddr0_i  input  ADDR_W  write index, port 0.
- wdata0_i  input  DATA_W  write data, port 0.
- waddr1_i  input  ADDR_W  write index, port 1.
- wdata1_i  input  DATA_W  write data, port 1.
- raddr0_i  input  ADDR_W  read index 0.
- rdata0_o  output  DATA_W  read data 0.
- raddr1_i  input  ADDR_W  read index 1.
- rdata1_o  output  DATA_W  read data 1.
- raddr2_i  input  ADDR_W  read index 2.
- rdata2_o  output  DATA_W  read data 2.
- raddr3_i  input  ADDR_W  read index 3.
- rdata3_o  output  DATA_W  read data 3.
- Port order is exactly as listed (positional instantiation is used).

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i).
- Reset: on a rising edge with rst_i=1, all 16 entries become 0. Reset overrides any write in the same cycle. With stable read indices, every rdataN_o reads 0 from the following edge onward.
- Write: on a rising edge with rst_i=0 and weK_i=1, mem[waddrK_i] <= wdataK_i. The write is visible on the read ports after that edge.
- Both ports writing the same index in one cycle: port 1 wins.
- Both ports writing different indices in one cycle: both writes occur.
- Index values are unsigned binary, 0..15. Every index is valid; no out-of-range condition exists. Entry 0 is ordinary storage, not hardwired to zero.
- Read: fully combinational. rdataN_o = mem[raddrN_i] with zero-cycle latency. Read ports are independent; any ports may address the same entry.
- Read-during-write (default build): a read of an index being written in the current cycle returns the old contents until the edge.
- X on a write enable is not handled; the implementation is not required to handle it.

Optional Feature:
- Macro: MEM_2W4R_BYPASS_EN.
- When defined: each read port forwards same-cycle write data. If weK_i=1 and waddrK_i==raddrN_i, rdataN_o = wdataK_i. Port 1 has priority over port 0. Forwarding is suppressed while rst_i=1.
- When undefined: plain array read, returning the old value as specified above.

Decomposition:
- Package mem_2w4r_pkg: DATA_W/ADDR_W/DEPTH defaults; reg index constants REG_FP=0 and REG_SP=1 used by the register-file wrapper.
- No sub-module required. An optional mem_2w4r_rdmux (one read port with bypass logic, instantiated 4x) is acceptable.

Test Plan:
- Reset: write 0xDEADBEEF to entry 5, assert rst_i for 1 cycle -> rdata0_o with raddr0_i=5 reads 0x00000000; all 16 entries read 0.
- Single writes: port0 writes 0x11111111 to idx 3; next cycle port1 writes 0x22222222 to idx 12 -> reads of 3 and 12 on all four ports return those values.
- Dual write, distinct indices: same cycle, we0 idx0=0xA0A0A0A0 and we1 idx1=0xB1B1B1B1 -> rdata2_o (raddr2=0)=0xA0A0A0A0, rdata3_o (raddr3=1)=0xB1B1B1B1.
- Dual write, same index: both ports write idx 7 (port0=0x1, port1=0x2) -> idx 7 reads 0x00000002.
- Read-during-write: idx 9 holds 0x5; write 0x6 to idx 9 -> before the edge rdata reads 0x5 (0x6 with MEM_2W4R_BYPASS_EN); after the edge reads 0x6.
- Reset vs write: rst_i=1 and we0=1 to idx 15 in the same cycle -> idx 15 reads 0.

Source files
------------

// File: rtl/mem_2w4r_pkg.sv
// Shared sizing and register-index constants for the 2-write / 4-read storage array.
// Consumers: mem_2w4r and the register-file wrapper that ties read ports 2/3 to fp/sp.
package mem_2w4r_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH  = 16;
  localparam int NUM_RD     = 4;

  // Fixed indices that the register-file wrapper drives onto read ports 2 and 3
  localparam logic [DEF_ADDR_W-1:0] REG_FP = 4'd0;
  localparam logic [DEF_ADDR_W-1:0] REG_SP = 4'd1;

endpackage

// File: rtl/mem_2w4r.sv
// 16x32 storage array with two synchronous write ports and four combinational read ports.
// Optional macro MEM_2W4R_BYPASS_EN forwards same-cycle write data to the read ports.
module mem_2w4r
  import mem_2w4r_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] waddr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [ADDR_W-1:0] waddr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [ADDR_W-1:0] raddr0_i,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic [ADDR_W-1:0] raddr3_i,
  output logic [DATA_W-1:0] rdata3_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Port 1 is assigned last so it wins when both ports target the same entry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (we0_i) begin
        mem[waddr0_i] <= wdata0_i;
      end
      if (we1_i) begin
        mem[waddr1_i] <= wdata1_i;
      end
    end
  end

`ifdef MEM_2W4R_BYPASS_EN

  // Forwarding mirrors the write priority; nothing is forwarded while the array is clearing
  function automatic logic [DATA_W-1:0] fwd_read(input logic [DATA_W-1:0] stored,
                                                 input logic [ADDR_W-1:0] raddr);
    fwd_read = stored;
    if (!rst_i) begin
      if (we0_i && (waddr0_i == raddr)) begin
        fwd_read = wdata0_i;
      end
      if (we1_i && (waddr1_i == raddr)) begin
        fwd_read = wdata1_i;
      end
    end
  endfunction

  always_comb begin
    rdata0_o = fwd_read(mem[raddr0_i], raddr0_i);
    rdata1_o = fwd_read(mem[raddr1_i], raddr1_i);
    rdata2_o = fwd_read(mem[raddr2_i], raddr2_i);
    rdata3_o = fwd_read(mem[raddr3_i], raddr3_i);
  end

`else

  assign rdata0_o = mem[raddr0_i];
  assign rdata1_o = mem[raddr1_i];
  assign rdata2_o = mem[raddr2_i];
  assign rdata3_o = mem[raddr3_i];

`endif

endmodule

// File: tb/tb_mem_2w4r.sv
// Self-checking bench for mem_2w4r: directed test-plan steps followed by randomized
// traffic checked against an array model (honours MEM_2W4R_BYPASS_EN when defined).
module tb_mem_2w4r;
  import mem_2w4r_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        we0_i = 1'b0;
  logic        we1_i = 1'b0;
  logic [3:0]  waddr0_i = '0;
  logic [31:0] wdata0_i = '0;
  logic [3:0]  waddr1_i = '0;
  logic [31:0] wdata1_i = '0;
  logic [3:0]  raddr0_i = '0;
  logic [31:0] rdata0_o;
  logic [3:0]  raddr1_i = '0;
  logic [31:0] rdata1_o;
  logic [3:0]  raddr2_i = '0;
  logic [31:0] rdata2_o;
  logic [3:0]  raddr3_i = '0;
  logic [31:0] rdata3_o;

  logic [31:0] model_mem [16];
  int check_cnt = 0;
  int pass_cnt  = 0;

  mem_2w4r dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we0_i    (we0_i),
    .we1_i    (we1_i),
    .waddr0_i (waddr0_i),
    .wdata0_i (wdata0_i),
    .waddr1_i (waddr1_i),
    .wdata1_i (wdata1_i),
    .raddr0_i (raddr0_i),
    .rdata0_o (rdata0_o),
    .raddr1_i (raddr1_i),
    .rdata1_o (rdata1_o),
    .raddr2_i (raddr2_i),
    .rdata2_o (rdata2_o),
    .raddr3_i (raddr3_i),
    .rdata3_o (rdata3_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // What a read port should show right now, from the stored model plus pending writes
  function automatic logic [31:0] model_read(input logic [3:0] idx);
    logic [31:0] v;
    v = model_mem[idx];
`ifdef MEM_2W4R_BYPASS_EN
    if (!rst_i) begin
      if (we0_i && waddr0_i == idx) v = wdata0_i;
      if (we1_i && waddr1_i == idx) v = wdata1_i;
    end
`endif
    return v;
  endfunction

  task automatic applyStimulus(input logic rst, input logic we0, input logic [3:0] a0,
                               input logic [31:0] d0, input logic we1, input logic [3:0] a1,
                               input logic [31:0] d1);
    rst_i = rst;
    we0_i = we0; waddr0_i = a0; wdata0_i = d0;
    we1_i = we1; waddr1_i = a1; wdata1_i = d1;
  endtask

  task automatic setReads(input logic [3:0] r0, input logic [3:0] r1,
                          input logic [3:0] r2, input logic [3:0] r3);
    raddr0_i = r0; raddr1_i = r1; raddr2_i = r2; raddr3_i = r3;
    #1;
  endtask

  // Clock edge: the model commits whatever the inputs requested, then inputs may move
  task automatic cycle();
    @(posedge clk_i);
    if (rst_i) begin
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
    end else begin
      if (we0_i) model_mem[waddr0_i] = wdata0_i;
      if (we1_i) model_mem[waddr1_i] = wdata1_i;
    end
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkPorts(input string tag);
    checkOutput({tag, "_rd0"}, rdata0_o, model_read(raddr0_i));
    checkOutput({tag, "_rd1"}, rdata1_o, model_read(raddr1_i));
    checkOutput({tag, "_rd2"}, rdata2_o, model_read(raddr2_i));
    checkOutput({tag, "_rd3"}, rdata3_o, model_read(raddr3_i));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model_mem[i] = 'x;
    $display("[TB] start");

    // Power-up reset
    applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    setReads(4'd0, 4'd1, 4'd2, 4'd3);
    checkOutput("init_rst_rd0", rdata0_o, 32'h0);
    checkOutput("init_rst_rd3", rdata3_o, 32'h0);

    // Reset clears previously written data across every entry
    applyStimulus(1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    setReads(4'd5, 4'd5, 4'd5, 4'd5);
    checkOutput("pre_rst_idx5", rdata0_o, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    #1;
    checkOutput("post_rst_idx5", rdata0_o, 32'h0);
    for (int i = 0; i < 16; i++) begin
      setReads(4'(i), 4'(i), 4'(i), 4'(i));
      checkOutput($sformatf("rst_all_rd0_%0d", i), rdata0_o, 32'h0);
      checkOutput($sformatf("rst_all_rd1_%0d", i), rdata1_o, 32'h0);
      checkOutput($sformatf("rst_all_rd2_%0d", i), rdata2_o, 32'h0);
      checkOutput($sformatf("rst_all_rd3_%0d", i), rdata3_o, 32'h0);
    end

    // Single writes on each port in consecutive cycles
    applyStimulus(1'b0, 1'b1, 4'd3, 32'h11111111, 1'b0, 4'd0, 32'd0);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd12, 32'h22222222);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    setReads(4'd3, 4'd12, 4'd3, 4'd12);
    checkOutput("single_rd0_3", rdata0_o, 32'h11111111);
    checkOutput("single_rd1_12", rdata1_o, 32'h22222222);
    checkOutput("single_rd2_3", rdata2_o, 32'h11111111);
    checkOutput("single_rd3_12", rdata3_o, 32'h22222222);
    setReads(4'd12, 4'd3, 4'd12, 4'd3);
    checkOutput("single_rd0_12", rdata0_o, 32'h22222222);
    checkOutput("single_rd1_3", rdata1_o, 32'h11111111);
    checkOutput("single_rd2_12", rdata2_o, 32'h22222222);
    checkOutput("single_rd3_3", rdata3_o, 32'h11111111);

    // Dual write to distinct indices, observed on the fp/sp ports
    applyStimulus(1'b0, 1'b1, 4'd0, 32'hA0A0A0A0, 1'b1, 4'd1, 32'hB1B1B1B1);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    setReads(4'd3, 4'd12, REG_FP, REG_SP);
    checkOutput("dual_fp", rdata2_o, 32'hA0A0A0A0);
    checkOutput("dual_sp", rdata3_o, 32'hB1B1B1B1);

    // Dual write to the same index: port 1 wins
    applyStimulus(1'b0, 1'b1, 4'd7, 32'h00000001, 1'b1, 4'd7, 32'h00000002);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    setReads(4'd7, 4'd7, 4'd0, 4'd1);
    checkOutput("same_idx7", rdata0_o, 32'h00000002);
    checkOutput("same_idx7_untouched_fp", rdata2_o, 32'hA0A0A0A0);

    // Read during write
    applyStimulus(1'b0, 1'b1, 4'd9, 32'h5, 1'b0, 4'd0, 32'd0);
    cycle();
    applyStimulus(1'b0, 1'b1, 4'd9, 32'h6, 1'b0, 4'd0, 32'd0);
    setReads(4'd9, 4'd9, 4'd9, 4'd9);
`ifdef MEM_2W4R_BYPASS_EN
    checkOutput("rdw_before_edge", rdata0_o, 32'h6);
`else
    checkOutput("rdw_before_edge", rdata0_o, 32'h5);
`endif
    cycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    #1;
    checkOutput("rdw_after_edge", rdata1_o, 32'h6);

    // Reset beats a same-cycle write, and suppresses forwarding before the edge
    applyStimulus(1'b0, 1'b1, 4'd15, 32'hCAFEF00D, 1'b0, 4'd0, 32'd0);
    cycle();
    applyStimulus(1'b1, 1'b1, 4'd15, 32'h12345678, 1'b0, 4'd0, 32'd0);
    setReads(4'd15, 4'd15, 4'd15, 4'd15);
    checkOutput("rst_vs_wr_before_edge", rdata0_o, 32'hCAFEF00D);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    #1;
    checkOutput("rst_vs_wr_idx15", rdata0_o, 32'h0);
    checkOutput("rst_vs_wr_idx15_rd3", rdata3_o, 32'h0);

    // Randomized traffic against the model, with frequent address collisions
    for (int n = 0; n < 300; n++) begin
      logic [3:0] a0, a1;
      a0 = 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 19) == 0), 1'($urandom), a0, $urandom,
                    1'($urandom), a1, $urandom);
      setReads(($urandom_range(0, 1) == 0) ? a0 : 4'($urandom_range(0, 15)),
               ($urandom_range(0, 1) == 0) ? a1 : 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      checkPorts($sformatf("rand%0d_pre", n));
      cycle();
      checkPorts($sformatf("rand%0d_post", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
